// File: rtl/hack_bitwise_pkg.sv
// Shared op codes for the Hack bitwise logic unit and the ALU front end.
// bit_op gives the single-bit truth table for each op.
package hack_bitwise_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT_A  = 3'd0;
  localparam logic [OP_W-1:0] OP_AND    = 3'd1;
  localparam logic [OP_W-1:0] OP_OR     = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND   = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR    = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR   = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS_A = 3'd7;

  function automatic logic bit_op(input logic [OP_W-1:0] op, input logic a, input logic b);
    logic r;
    r = a;
    case (op)
      OP_NOT_A:  r = ~a;
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XNOR:   r = ~(a ^ b);
      OP_PASS_A: r = a;
      default:   r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitwise_core.sv
// Combinational WIDTH-bit bitwise logic core; zr/ng flag outputs exist only
// when BITWISE_UNIT_FLAGS_EN is defined.
module bitwise_core
  import hack_bitwise_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
`ifdef BITWISE_UNIT_FLAGS_EN
  ,
  output logic             zr,
  output logic             ng
`endif
);

  // Each result bit sees only its own operand bits: no carries between lanes.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign y[gi] = bit_op(op, a[gi], b[gi]);
    end
  endgenerate

`ifdef BITWISE_UNIT_FLAGS_EN
  assign zr = (y == '0);
  assign ng = y[WIDTH-1];
`endif

endmodule

// File: rtl/bitwise_unit_pipe.sv
// Registered bitwise logic unit with valid/ready ports and a 2-entry output
// buffer. Define BITWISE_UNIT_FLAGS_EN to add per-result out_zr/out_ng.
module bitwise_unit_pipe
  import hack_bitwise_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BITWISE_UNIT_FLAGS_EN
  ,
  output logic             out_zr,
  output logic             out_ng
`endif
);

  generate
    if (DEPTH != 2) begin : g_depth_check
      $error("bitwise_unit_pipe: DEPTH must be 2");
    end
  endgenerate

  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] data_mem [0:1];
  logic             head_reg;
  logic             tail_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             push;
  logic             pop;

`ifdef BITWISE_UNIT_FLAGS_EN
  logic core_zr;
  logic core_ng;
  logic zr_mem [0:1];
  logic ng_mem [0:1];
`endif

  bitwise_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (in_a),
    .b  (in_b),
    .op (in_op),
    .y  (core_y)
`ifdef BITWISE_UNIT_FLAGS_EN
    ,
    .zr (core_zr),
    .ng (core_ng)
`endif
  );

  // in_ready is a function of buffer state only, so it never loops back from out_ready.
  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = data_mem[head_reg];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef BITWISE_UNIT_FLAGS_EN
  assign out_zr = zr_mem[head_reg];
  assign out_ng = ng_mem[head_reg];
`endif

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Entries are cleared on reset so out_data reads zero until the first result lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 2'd0;
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
`ifdef BITWISE_UNIT_FLAGS_EN
        zr_mem[i]   <= 1'b0;
        ng_mem[i]   <= 1'b0;
`endif
      end
    end else begin
      count_reg <= count_next;
      if (push) begin
        data_mem[tail_reg] <= core_y;
`ifdef BITWISE_UNIT_FLAGS_EN
        zr_mem[tail_reg]   <= core_zr;
        ng_mem[tail_reg]   <= core_ng;
`endif
        tail_reg <= ~tail_reg;
      end
      if (pop) begin
        head_reg <= ~head_reg;
      end
    end
  end

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Self-checking bench for bitwise_unit_pipe: directed table, backpressure,
// reset and random streaming against a queue-based reference model.
module tb_bitwise_unit_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  logic        w8_in_valid;
  logic        w8_in_ready;
  logic [2:0]  w8_in_op;
  logic [7:0]  w8_in_a;
  logic [7:0]  w8_in_b;
  logic        w8_out_valid;
  logic        w8_out_ready;
  logic [7:0]  w8_out_data;

`ifdef BITWISE_UNIT_FLAGS_EN
  logic out_zr, out_ng, w8_out_zr, w8_out_ng;
`endif

  int vectors = 0;
  int miscompares = 0;

  bitwise_unit_pipe #(.WIDTH(16), .DEPTH(2)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef BITWISE_UNIT_FLAGS_EN
    , .out_zr(out_zr), .out_ng(out_ng)
`endif
  );

  bitwise_unit_pipe #(.WIDTH(8), .DEPTH(2)) u_dut8 (
    .clk(clk), .reset(reset),
    .in_valid(w8_in_valid), .in_ready(w8_in_ready), .in_op(w8_in_op), .in_a(w8_in_a), .in_b(w8_in_b),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready), .out_data(w8_out_data)
`ifdef BITWISE_UNIT_FLAGS_EN
    , .out_zr(w8_out_zr), .out_ng(w8_out_ng)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
  } vec_t;

  vec_t vt [8];
  logic [15:0] q [$];

  initial begin
    vt[0] = '{3'd0, 16'hF0F0, 16'hCCCC, 16'h0F0F};
    vt[1] = '{3'd1, 16'hF0F0, 16'hCCCC, 16'hC0C0};
    vt[2] = '{3'd2, 16'hF0F0, 16'hCCCC, 16'hFCFC};
    vt[3] = '{3'd3, 16'hF0F0, 16'hCCCC, 16'h3C3C};
    vt[4] = '{3'd4, 16'hF0F0, 16'hCCCC, 16'h3F3F};
    vt[5] = '{3'd5, 16'hF0F0, 16'hCCCC, 16'h0303};
    vt[6] = '{3'd6, 16'hF0F0, 16'hCCCC, 16'hC3C3};
    vt[7] = '{3'd7, 16'hF0F0, 16'hCCCC, 16'hF0F0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0;
    w8_in_valid = 1'b0; w8_out_ready = 1'b0; w8_in_op = 3'd0; w8_in_a = '0; w8_in_b = '0;
    step(); step();
    reset = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_data", out_data, 0);

    // Single beat, one-cycle latency, then empty again.
    in_valid = 1'b1; in_op = 3'd0; in_a = 16'h00FF; in_b = 16'h1234; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_out_valid", out_valid, 1);
    check("single_out_data", out_data, 16'hFF00);
    step();
    check("single_drained", out_valid, 0);

    // All ops back-to-back at one beat per cycle.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_op = vt[i].op; in_a = vt[i].a; in_b = vt[i].b;
      check("ops_in_ready", in_ready, 1);
      step();
      check("ops_out_valid", out_valid, 1);
      check("ops_out_data", out_data, vt[i].y);
    end
    in_valid = 1'b0;
    step();
    check("ops_drained", out_valid, 0);

    // Backpressure: two beats fill the buffer, third stalls.
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd7; in_a = 16'h0001;
    step();
    in_a = 16'h0002;
    step();
    in_a = 16'h0003;
    check("bp_full_in_ready", in_ready, 0);
    check("bp_head", out_data, 16'h0001);
    step();
    check("bp_hold_data", out_data, 16'h0001);
    check("bp_hold_valid", out_valid, 1);
    check("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    step();
    check("bp_second", out_data, 16'h0002);
    check("bp_reopen", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_third", out_data, 16'h0003);
    check("bp_third_valid", out_valid, 1);
    step();
    check("bp_drained", out_valid, 0);

    // Reset while full: buffered results are discarded.
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd7; in_a = 16'hAAAA;
    step();
    in_a = 16'h5555;
    step();
    check("rst_full_in_ready", in_ready, 0);
    in_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_data", out_data, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_no_stale", out_valid, 0);
    end

    // Random streaming against the queue model.
    begin
      int sent;
      int cyc;
      logic push, pop;
      logic [15:0] exp_y;
      sent = 0;
      cyc = 0;
      q.delete();
      while (sent < 100 && cyc < 2000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_op     = 3'($urandom_range(0, 7));
        in_a      = 16'($urandom);
        in_b      = 16'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        check("rnd_in_ready", in_ready, (q.size() < 2) ? 1 : 0);
        check("rnd_out_valid", out_valid, (q.size() > 0) ? 1 : 0);
        if (q.size() > 0) check("rnd_out_data", out_data, q[0]);
        push  = in_valid && (q.size() < 2);
        pop   = out_ready && (q.size() > 0);
        exp_y = ref_op(in_op, in_a, in_b);
        step();
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back(exp_y);
          sent++;
        end
        cyc++;
      end
      check("rnd_all_sent", sent, 100);
      in_valid = 1'b0; out_ready = 1'b1;
      cyc = 0;
      while (q.size() > 0 && cyc < 10) begin
        check("drain_out_valid", out_valid, 1);
        check("drain_out_data", out_data, q[0]);
        void'(q.pop_front());
        step();
        cyc++;
      end
      check("drain_done", out_valid, 0);
    end

`ifdef BITWISE_UNIT_FLAGS_EN
    in_valid = 1'b1; in_op = 3'd1; in_a = 16'h00FF; in_b = 16'hFF00; out_ready = 1'b1;
    step();
    in_op = 3'd0; in_a = 16'h0000;
    check("flag_and_data", out_data, 16'h0000);
    check("flag_and_zr", out_zr, 1);
    check("flag_and_ng", out_ng, 0);
    step();
    in_valid = 1'b0;
    check("flag_not_data", out_data, 16'hFFFF);
    check("flag_not_zr", out_zr, 0);
    check("flag_not_ng", out_ng, 1);
    step();
`endif

    // Narrow instance.
    w8_in_valid = 1'b1; w8_in_op = 3'd0; w8_in_a = 8'h5A; w8_in_b = 8'h00; w8_out_ready = 1'b1;
    step();
    w8_in_valid = 1'b0;
    check("w8_out_valid", w8_out_valid, 1);
    check("w8_not", w8_out_data, 8'hA5);
    step();
    check("w8_drained", w8_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
